// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding and frame field sizes for the boot loader.
package imem_boot_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CNT, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int ADDR_BYTES = 8;
    localparam int CNT_BYTES = 2;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// imem_boot_loader_byte_packer: little-endian shift-in assembler of N bytes with a last-byte flag.
module imem_boot_loader_byte_packer #(
    parameter int N = 4
) (
    input  logic           CLK,
    input  logic           resetl,
    input  logic           clr_i,
    input  logic           shift_i,
    input  logic [7:0]     data_i,
    output logic [8*N-1:0] val_o,
    output logic           full_o
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] idx_q, idx_d;
    assign full_o = idx_q == IW'(N - 1);
    assign idx_d  = full_o ? '0 : idx_q + IW'(1);
    always_ff @(posedge CLK) begin
        if (resetl) begin
            idx_q <= '0;
            val_o <= '0;
        end else if (clr_i) begin
            idx_q <= '0;
        end else if (shift_i) begin
            idx_q <= idx_d;
            val_o <= {data_i, val_o[8*N-1:8]};
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte-serial program image, writes it to instruction memory
// and releases the core at the frame's base address once the checksum matches.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int         MAX_WORDS = 256,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        imem_we_o,
    output logic [63:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic [63:0] startpc_o,
    output logic        cpu_resetl_o,
    output logic        boot_done_o,
    output logic        boot_err_o,
    output logic [15:0] words_written_o
);
    state_t state_q;
    logic [7:0] csum_q;
    logic [63:0] base;
    logic [15:0] cnt, cnt_d, words_d;
    logic acc, sync, base_full, cnt_full, word_full, cnt_bad, csum_ok;
    assign acc     = in_valid_i && in_ready_o;
    assign sync    = acc && in_data_i == SYNC_BYTE && (state_q == S_IDLE || state_q == S_ERR);
    assign cnt_d   = {in_data_i, cnt[15:8]};
    assign cnt_bad = cnt_d == 16'd0 || int'(cnt_d) > MAX_WORDS;
    assign words_d = words_written_o + 16'd1;
    assign csum_ok = in_data_i == csum_q;

    imem_boot_loader_byte_packer #(.N(ADDR_BYTES)) u_base (
        .CLK(CLK), .resetl(resetl), .clr_i(sync), .shift_i(acc && state_q == S_ADDR),
        .data_i(in_data_i), .val_o(base), .full_o(base_full));
    imem_boot_loader_byte_packer #(.N(CNT_BYTES)) u_cnt (
        .CLK(CLK), .resetl(resetl), .clr_i(sync), .shift_i(acc && state_q == S_CNT),
        .data_i(in_data_i), .val_o(cnt), .full_o(cnt_full));
    // The word packer holds the completed word exactly in the cycle imem_we pulses.
    imem_boot_loader_byte_packer #(.N(WORD_BYTES)) u_word (
        .CLK(CLK), .resetl(resetl), .clr_i(sync), .shift_i(acc && state_q == S_DATA),
        .data_i(in_data_i), .val_o(imem_wdata_o), .full_o(word_full));

    always_ff @(posedge CLK) begin
        if (resetl) begin
            state_q         <= S_IDLE;
            csum_q          <= '0;
            in_ready_o      <= 1'b1;
            imem_we_o       <= 1'b0;
            imem_addr_o     <= '0;
            startpc_o       <= '0;
            cpu_resetl_o    <= 1'b0;
            boot_done_o     <= 1'b0;
            boot_err_o      <= 1'b0;
            words_written_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            if (acc) begin
                csum_q <= csum_q ^ in_data_i;
                case (state_q)
                    S_IDLE, S_ERR: if (sync) begin
                        state_q         <= S_ADDR;
                        csum_q          <= '0;
                        words_written_o <= '0;
                        boot_err_o      <= 1'b0;
                    end
                    // On the 8th byte the first address byte sits at base[15:8].
                    S_ADDR: if (base_full) begin
                        state_q    <= base[9:8] != 2'b00 ? S_ERR : S_CNT;
                        boot_err_o <= base[9:8] != 2'b00;
                    end
                    S_CNT: if (cnt_full) begin
                        state_q    <= cnt_bad ? S_ERR : S_DATA;
                        boot_err_o <= cnt_bad;
                    end
                    S_DATA: if (word_full) begin
                        imem_we_o       <= 1'b1;
                        imem_addr_o     <= base + {46'd0, words_written_o, 2'b00};
                        words_written_o <= words_d;
                        state_q         <= words_d == cnt ? S_CSUM : S_DATA;
                    end
                    S_CSUM: begin
                        state_q      <= csum_ok ? S_DONE : S_ERR;
                        boot_done_o  <= csum_ok;
                        boot_err_o   <= !csum_ok;
                        cpu_resetl_o <= csum_ok;
                        in_ready_o   <= !csum_ok;
                        startpc_o    <= csum_ok ? base : startpc_o;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven frame vectors plus hand sequences for re-sync, DONE hold
// and mid-frame reset.
module tb_imem_boot_loader;
    logic CLK = 1'b0, resetl = 1'b1, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready_o, imem_we_o, cpu_resetl_o, boot_done_o, boot_err_o;
    logic [63:0] imem_addr_o, startpc_o;
    logic [31:0] imem_wdata_o;
    logic [15:0] words_written_o;

    imem_boot_loader dut (
        .CLK(CLK), .resetl(resetl), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
        .imem_wdata_o(imem_wdata_o), .startpc_o(startpc_o), .cpu_resetl_o(cpu_resetl_o),
        .boot_done_o(boot_done_o), .boot_err_o(boot_err_o), .words_written_o(words_written_o));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] base;
        logic [15:0] cnt;
        logic [31:0] w0, w1;
        int          stage;
        logic [7:0]  flip;
        bit          garbage, gap, exp_done;
        int          exp_wr;
    } vec_t;

    vec_t tbl[9];
    int checks = 0, errors = 0, cyc = 0, last_we = -1, rise = -1;
    logic [63:0] wa[$];
    logic [31:0] wd[$];

    always @(negedge CLK) begin
        cyc++;
        if (imem_we_o) begin
            wa.push_back(imem_addr_o);
            wd.push_back(imem_wdata_o);
            last_we = cyc;
        end
        if (cpu_resetl_o && rise < 0) rise = cyc;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input vec_t v, input int i);
        return i == 0 ? v.w0 : i == 1 ? v.w1 : v.w0 ^ {i[15:0], i[15:0]};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        resetl = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        resetl = 1'b0;
        wa.delete();
        wd.delete();
        rise = -1;
        last_we = -1;
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_rst_ready"}, in_ready_o, 1);
        chk({t, "_rst_we"}, imem_we_o, 0);
        chk({t, "_rst_addr"}, imem_addr_o, 0);
        chk({t, "_rst_wdata"}, imem_wdata_o, 0);
        chk({t, "_rst_startpc"}, startpc_o, 0);
        chk({t, "_rst_cpu"}, cpu_resetl_o, 0);
        chk({t, "_rst_done"}, boot_done_o, 0);
        chk({t, "_rst_err"}, boot_err_o, 0);
        chk({t, "_rst_words"}, words_written_o, 0);
    endtask

    // Entered and left at a negedge; bytes are back-to-back unless gap is set.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready_o && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte %h never accepted", b);
        end else begin
            @(posedge CLK);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        if (gap) @(negedge CLK);
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] cs = 8'h00, b;
        logic [31:0] w;
        if (v.garbage) begin
            send_byte(8'h00, v.gap);
            send_byte(8'h5A, v.gap);
        end
        send_byte(8'hA5, v.gap);
        for (int i = 0; i < 8; i++) begin
            b = v.base[8*i +: 8];
            cs ^= b;
            send_byte(b, v.gap);
        end
        if (v.stage >= 2) begin
            for (int i = 0; i < 2; i++) begin
                b = v.cnt[8*i +: 8];
                cs ^= b;
                send_byte(b, v.gap);
            end
        end
        if (v.stage >= 3) begin
            for (int i = 0; i < int'(v.cnt); i++) begin
                w = word(v, i);
                for (int j = 0; j < 4; j++) begin
                    b = w[8*j +: 8];
                    cs ^= b;
                    send_byte(b, v.gap);
                end
            end
            send_byte(cs ^ v.flip, v.gap);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic chk_frame(input string t, input vec_t v);
        chk({t, "_done"}, boot_done_o, v.exp_done);
        chk({t, "_err"}, boot_err_o, !v.exp_done);
        chk({t, "_cpu"}, cpu_resetl_o, v.exp_done);
        chk({t, "_ready"}, in_ready_o, !v.exp_done);
        chk({t, "_startpc"}, startpc_o, v.exp_done ? v.base : 64'd0);
        chk({t, "_nwr"}, wa.size(), v.exp_wr);
        chk({t, "_words"}, words_written_o, v.exp_wr);
        for (int i = 0; i < wa.size() && i < v.exp_wr; i++) begin
            chk($sformatf("%s_addr%0d", t, i), wa[i], v.base + 64'(4 * i));
            chk($sformatf("%s_data%0d", t, i), wd[i], word(v, i));
        end
        if (v.exp_done && v.exp_wr > 0) chk({t, "_release_after_we"}, rise > last_we, 1);
    endtask

    initial begin
        tbl[0] = '{64'h0, 16'd2, 32'h8B1F03E9, 32'hF84003E9, 3, 8'h00, 0, 0, 1, 2};
        tbl[1] = '{64'h0, 16'd2, 32'h8B1F03E9, 32'hF84003E9, 3, 8'h01, 0, 0, 0, 2};
        tbl[2] = '{64'h2, 16'd2, 32'h0, 32'h0, 1, 8'h00, 0, 0, 0, 0};
        tbl[3] = '{64'h100, 16'd0, 32'h0, 32'h0, 2, 8'h00, 0, 0, 0, 0};
        tbl[4] = '{64'h100, 16'd257, 32'h0, 32'h0, 2, 8'h00, 0, 0, 0, 0};
        tbl[5] = '{64'hFFFFFFFFFFFFFFFC, 16'd2, 32'hDEADBEEF, 32'h01234567, 3, 8'h00, 0, 0, 1, 2};
        tbl[6] = '{64'h1000, 16'd1, 32'h12345678, 32'h0, 3, 8'h00, 1, 0, 1, 1};
        tbl[7] = '{64'h2000, 16'd2, 32'h8B1F03E9, 32'hF84003E9, 3, 8'h00, 0, 1, 1, 2};
        tbl[8] = '{64'h80000, 16'd256, 32'hCAFE0000, 32'h55AA55AA, 3, 8'h00, 0, 0, 1, 256};

        do_reset();
        chk_reset("init");
        for (int r = 0; r < 9; r++) begin
            do_reset();
            send_frame(tbl[r]);
            chk_frame($sformatf("row%0d", r), tbl[r]);
        end

        // Bad checksum, then a good frame re-syncs without reset.
        do_reset();
        send_frame(tbl[1]);
        chk("resync_err_first", boot_err_o, 1);
        wa.delete();
        wd.delete();
        send_frame(tbl[0]);
        chk_frame("resync", tbl[0]);

        // DONE holds: offered bytes are not taken and nothing moves.
        in_data = 8'hA5;
        in_valid = 1'b1;
        repeat (5) @(negedge CLK);
        in_valid = 1'b0;
        chk("hold_ready", in_ready_o, 0);
        chk("hold_done", boot_done_o, 1);
        chk("hold_cpu", cpu_resetl_o, 1);
        chk("hold_startpc", startpc_o, 64'h0);
        chk("hold_nwr", wa.size(), 2);

        // Reset after 2 of 4 data bytes, coinciding with a handshake.
        do_reset();
        send_byte(8'hA5, 0);
        for (int i = 0; i < 8; i++) send_byte(i == 1 ? 8'h03 : 8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        in_data = 8'h33;
        in_valid = 1'b1;
        resetl = 1'b1;
        @(negedge CLK);
        resetl = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midrst_nwr", wa.size(), 0);
        chk_reset("midrst");
        send_frame(tbl[0]);
        chk_frame("after_midrst", tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
